// File: rtl/instr_stats_pkg.sv
// Shared definitions for the instruction statistics path: sizes, RV32 major
// opcodes, class indices and the dump FSM state encoding.
package instr_stats_pkg;

   localparam int unsigned DEF_INSTR_W = 32;
   localparam int unsigned DEF_CNT_W   = 17;
   localparam int unsigned DEF_NUM_CLS = 9;
   localparam int unsigned CLS_W       = 4;
   localparam int unsigned OPC_W       = 7;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

   typedef enum logic [CLS_W-1:0] {
      CLS_R      = 4'd0,
      CLS_I      = 4'd1,
      CLS_STORE  = 4'd2,
      CLS_LOAD   = 4'd3,
      CLS_BRANCH = 4'd4,
      CLS_LUI    = 4'd5,
      CLS_AUIPC  = 4'd6,
      CLS_JAL    = 4'd7,
      CLS_JALR   = 4'd8
   } cls_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier shared with the retire-counting logic.
// Ports:
//   opcode  - instruction bits [6:0]
//   hit     - opcode belongs to one of the counted classes
//   cls_idx - class index (valid only when hit is high, 0 otherwise)
module instr_class_decode
   import instr_stats_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             hit,
   output logic [CLS_W-1:0] cls_idx
);

   always_comb begin
      hit     = 1'b1;
      cls_idx = CLS_R;
      case (opcode)
         OP_R:      cls_idx = CLS_R;
         OP_I:      cls_idx = CLS_I;
         OP_STORE:  cls_idx = CLS_STORE;
         OP_LOAD:   cls_idx = CLS_LOAD;
         OP_BRANCH: cls_idx = CLS_BRANCH;
         OP_LUI:    cls_idx = CLS_LUI;
         OP_AUIPC:  cls_idx = CLS_AUIPC;
         OP_JAL:    cls_idx = CLS_JAL;
         OP_JALR:   cls_idx = CLS_JALR;
         default:   hit     = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_stats_dump.sv
// Live per-class retire counters with a snapshot-and-stream dump port.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   retire_valid    - instruction retires this cycle
//   retire_instr    - retiring instruction (only [6:0] used)
//   retire_flush    - suppresses counting while high
//   clear           - zeroes all live counters (wins over an increment)
//   dump_req        - starts a dump when the FSM is idle
//   dump_busy       - dump in progress
//   out_valid/ready - beat handshake
//   out_idx         - class index of the current beat
//   out_data        - snapshot count for out_idx
//   out_last        - final beat of the dump
module instr_stats_dump
   import instr_stats_pkg::*;
#(
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned NUM_CLS = DEF_NUM_CLS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               retire_valid,
   input  logic [INSTR_W-1:0] retire_instr,
   input  logic               retire_flush,
   input  logic               clear,
   input  logic               dump_req,
   output logic               dump_busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLS_W-1:0]   out_idx,
   output logic [CNT_W-1:0]   out_data,
   output logic               out_last
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLS - 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] live   [NUM_CLS];
   logic [CNT_W-1:0] shadow [NUM_CLS];

   logic             dec_hit;
   logic [CLS_W-1:0] dec_cls;
   logic             count_en;
   logic             capture;
   logic [CLS_W-1:0] idx_nxt;
   logic [CNT_W-1:0] data_nxt;
   logic             unused_instr_hi;

   assign unused_instr_hi = ^retire_instr[INSTR_W-1:OPC_W];

   instr_class_decode u_decode (
      .opcode  (retire_instr[OPC_W-1:0]),
      .hit     (dec_hit),
      .cls_idx (dec_cls)
   );

   assign count_en = retire_valid & ~retire_flush & dec_hit;

   // Live counters: clear has priority, increments saturate at all-ones.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_CLS; i++) live[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CLS; i++) begin
            if (count_en && dec_cls == CLS_W'(i) && live[i] != CNT_MAX)
               live[i] <= live[i] + CNT_W'(1);
         end
      end
   end

   // Snapshot takes the pre-edge live values, so same-cycle updates are excluded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CLS; i++) shadow[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < NUM_CLS; i++) shadow[i] <= live[i];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state, beat index and the data word to present next cycle.
   always_comb begin
      state_nxt = state;
      idx_nxt   = out_idx;
      capture   = 1'b0;
      data_nxt  = '0;
      case (state)
         IDLE: begin
            if (dump_req) begin
               capture   = 1'b1;
               state_nxt = SEND;
               idx_nxt   = '0;
            end
         end
         SEND: begin
            if (out_valid && out_ready) begin
               if (out_idx == LAST_IDX) begin
                  state_nxt = IDLE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = out_idx + CLS_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // First beat bypasses the shadow since it is being loaded on the same edge.
      if (capture)                data_nxt = live[0];
      else if (state_nxt == SEND) data_nxt = shadow[idx_nxt];
   end

   // Registered beat outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dump_busy <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= (state_nxt == SEND);
         dump_busy <= (state_nxt == SEND);
         out_idx   <= idx_nxt;
         out_data  <= data_nxt;
         out_last  <= (state_nxt == SEND) && (idx_nxt == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_instr_stats_dump.sv
// Scoreboard bench for instr_stats_dump. A full-width instance and a narrow
// (10-bit counter) instance see identical stimulus; the narrow one makes
// saturation reachable in a short run.
module tb_instr_stats_dump;

   localparam int NCLS    = 9;
   localparam int MAX_M   = 131071;
   localparam int SAT_W   = 10;
   localparam int MAX_S   = 1023;

   localparam logic [31:0] I_R   = 32'h0000_0033;
   localparam logic [31:0] I_I   = 32'h0000_0013;
   localparam logic [31:0] I_ST  = 32'h0000_0023;
   localparam logic [31:0] I_LD  = 32'h0000_0003;
   localparam logic [31:0] I_BR  = 32'h0000_0063;
   localparam logic [31:0] I_LUI = 32'h0000_0037;
   localparam logic [31:0] I_AUI = 32'h0000_0017;
   localparam logic [31:0] I_JAL = 32'h0000_006F;
   localparam logic [31:0] I_JR  = 32'h0000_0067;
   localparam logic [31:0] I_BAD = 32'hFFFF_FF80;

   typedef struct {
      int idx;
      int data;
      bit last;
   } beat_t;

   logic        clk;
   logic        reset;
   logic        retire_valid;
   logic [31:0] retire_instr;
   logic        retire_flush;
   logic        clear;
   logic        dump_req;
   logic        out_ready;

   logic             m_busy, m_valid, m_last;
   logic [3:0]       m_idx;
   logic [16:0]      m_data;
   logic             s_busy, s_valid, s_last;
   logic [3:0]       s_idx;
   logic [SAT_W-1:0] s_data;

   int    total = 0;
   int    bad   = 0;
   int    cnt [NCLS];
   bit    mdl_send;
   int    mdl_beats;
   beat_t q_main [$];
   beat_t q_sat  [$];
   beat_t e_m, e_s;
   logic [31:0] seq [10];

   instr_stats_dump dut (
      .clk          (clk),
      .reset        (reset),
      .retire_valid (retire_valid),
      .retire_instr (retire_instr),
      .retire_flush (retire_flush),
      .clear        (clear),
      .dump_req     (dump_req),
      .dump_busy    (m_busy),
      .out_valid    (m_valid),
      .out_ready    (out_ready),
      .out_idx      (m_idx),
      .out_data     (m_data),
      .out_last     (m_last)
   );

   instr_stats_dump #(.CNT_W(SAT_W)) dut_sat (
      .clk          (clk),
      .reset        (reset),
      .retire_valid (retire_valid),
      .retire_instr (retire_instr),
      .retire_flush (retire_flush),
      .clear        (clear),
      .dump_req     (dump_req),
      .dump_busy    (s_busy),
      .out_valid    (s_valid),
      .out_ready    (out_ready),
      .out_idx      (s_idx),
      .out_data     (s_data),
      .out_last     (s_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int cls_of(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      case (op)
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0100011: return 2;
         7'b0000011: return 3;
         7'b1100011: return 4;
         7'b0110111: return 5;
         7'b0010111: return 6;
         7'b1101111: return 7;
         7'b1100111: return 8;
         default:    return -1;
      endcase
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Apply the driven inputs to the reference counts, then advance one clock.
   task automatic tick();
      int c;
      if (reset) begin
         for (int i = 0; i < NCLS; i++) cnt[i] = 0;
         mdl_send = 1'b0;
         q_main.delete();
         q_sat.delete();
      end else begin
         if (mdl_send) begin
            if (out_ready) begin
               mdl_beats++;
               if (mdl_beats == NCLS) mdl_send = 1'b0;
            end
         end else if (dump_req) begin
            for (int i = 0; i < NCLS; i++) begin
               q_main.push_back('{i, sat(cnt[i], MAX_M), i == NCLS - 1});
               q_sat.push_back('{i, sat(cnt[i], MAX_S), i == NCLS - 1});
            end
            mdl_send  = 1'b1;
            mdl_beats = 0;
         end
         c = cls_of(retire_instr);
         if (clear) begin
            for (int i = 0; i < NCLS; i++) cnt[i] = 0;
         end else if (retire_valid && !retire_flush && c >= 0) begin
            cnt[c]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] ins, input logic fl);
      retire_valid = 1'b1;
      retire_instr = ins;
      retire_flush = fl;
      tick();
      retire_valid = 1'b0;
      retire_flush = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic start_dump();
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      out_ready = 1'b1;
      while (mdl_send && guard < 100) begin
         tick();
         guard++;
      end
   endtask

   // Scoreboard monitor, full-width instance.
   always @(negedge clk) begin
      if (!reset && m_valid) begin
         if (q_main.size() == 0) begin
            total++;
            bad++;
            $display("FAIL main_unexpected_beat actual_idx=%0d required=none", m_idx);
         end else begin
            e_m = q_main[0];
            chk("main_idx",  int'(m_idx),  e_m.idx);
            chk("main_data", int'(m_data), e_m.data);
            chk("main_last", int'(m_last), int'(e_m.last));
            chk("main_busy", int'(m_busy), 1);
            if (out_ready) q_main.delete(0);
         end
      end
   end

   // Scoreboard monitor, narrow instance.
   always @(negedge clk) begin
      if (!reset && s_valid) begin
         if (q_sat.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sat_unexpected_beat actual_idx=%0d required=none", s_idx);
         end else begin
            e_s = q_sat[0];
            chk("sat_idx",  int'(s_idx),  e_s.idx);
            chk("sat_data", int'(s_data), e_s.data);
            chk("sat_last", int'(s_last), int'(e_s.last));
            if (out_ready) q_sat.delete(0);
         end
      end
   end

   initial begin
      int k;
      seq = '{I_R, I_I, I_ST, I_LD, I_BR, I_LUI, I_AUI, I_JAL, I_JR, I_BAD};
      reset        = 1'b1;
      retire_valid = 1'b0;
      retire_instr = '0;
      retire_flush = 1'b0;
      clear        = 1'b0;
      dump_req     = 1'b0;
      out_ready    = 1'b1;
      mdl_send     = 1'b0;
      mdl_beats    = 0;
      for (int i = 0; i < NCLS; i++) cnt[i] = 0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state.
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_busy",  int'(m_busy),  0);
      chk("rst_idx",   int'(m_idx),   0);
      chk("rst_data",  int'(m_data),  0);
      chk("rst_last",  int'(m_last),  0);

      // One of each opcode plus an uncounted one, then a full-speed dump.
      for (int i = 0; i < 10; i++) retire(seq[i], 1'b0);
      start_dump();
      chk("first_beat_valid", int'(m_valid), 1);
      drain();
      chk("after_dump_busy",  int'(m_busy),  0);
      chk("after_dump_valid", int'(m_valid), 0);

      // Flushed retires must not count.
      do_clear();
      for (int i = 0; i < 3; i++) retire(I_R, 1'b1);
      for (int i = 0; i < 2; i++) retire(I_R, 1'b0);
      start_dump();
      drain();

      // Saturation: the narrow instance pins at its maximum.
      do_clear();
      retire_valid = 1'b1;
      retire_instr = I_LD;
      for (int i = 0; i < MAX_S + 5; i++) tick();
      retire_valid = 1'b0;
      start_dump();
      drain();

      // Back-pressure with retires continuing during the dump; the retire in
      // the request cycle is not part of the snapshot.
      do_clear();
      retire(I_R, 1'b0);
      retire(I_R, 1'b0);
      for (int i = 0; i < 3; i++) retire(I_I, 1'b0);
      retire_valid = 1'b1;
      retire_instr = I_R;
      start_dump();
      retire_instr = I_I;
      k = 0;
      while (mdl_send && k < 200) begin
         out_ready = ((k % 3) == 0);
         retire_valid = 1'b1;
         tick();
         k++;
      end
      retire_valid = 1'b0;
      out_ready = 1'b1;
      start_dump();
      drain();

      // clear beats a same-cycle increment; a request during SEND is dropped.
      retire_valid = 1'b1;
      retire_instr = I_R;
      clear        = 1'b1;
      tick();
      retire_valid = 1'b0;
      clear        = 1'b0;
      start_dump();
      tick();
      tick();
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      drain();
      tick();
      tick();
      chk("no_extra_dump_valid", int'(m_valid), 0);

      // Reset while the fourth beat is on the bus.
      retire(I_JAL, 1'b0);
      retire(I_BR, 1'b0);
      start_dump();
      tick();
      tick();
      tick();
      chk("pre_reset_idx", int'(m_idx), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_reset_valid", int'(m_valid), 0);
      chk("post_reset_busy",  int'(m_busy),  0);
      chk("post_reset_idx",   int'(m_idx),   0);
      start_dump();
      drain();

      tick();
      tick();
      chk("end_main_queue", q_main.size(), 0);
      chk("end_sat_queue",  q_sat.size(),  0);
      chk("end_valid",      int'(m_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
